// File: rtl/temp_sample_ctrl.sv
// DS18B20 sampling controller: sequences driver enables, captures synchronized
// results into a signed temperature with alarm flags and a sticky timeout error.
module temp_sample_ctrl #(
    parameter int unsigned        PERIOD_CYC  = 50_000_000,
    parameter int unsigned        TIMEOUT_CYC = 50_000_000,
    parameter logic signed [21:0] HI_THRESH   = 22'sd500000,
    parameter logic signed [21:0] LO_THRESH   = -22'sd100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic        stop,
    output logic        drv_enable,
    input  logic [20:0] drv_temp,
    input  logic        drv_sign,
    input  logic        drv_vld,
    output logic [21:0] temp_out,
    output logic        sample_vld,
    output logic        alarm_hi,
    output logic        alarm_lo,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_WAIT} state_t;

    localparam logic [25:0] CNT_MAX      = '1;
    localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYC - 1);
    localparam logic [25:0] PERIOD_LAST  = 26'(PERIOD_CYC - 1);

    state_t             state_q, state_d;
    logic [25:0]        cnt_q, cnt_d, cnt_inc;
    logic               cont_q, cont_d;
    logic               sync1_q, sync2_q, sync3_q, pulse_q;
    logic               drv_enable_q, drv_enable_d;
    logic signed [21:0] temp_q, temp_d;
    logic               sample_vld_q, sample_vld_d;
    logic               alarm_hi_q, alarm_hi_d;
    logic               alarm_lo_q, alarm_lo_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic signed [21:0] mag, temp_calc;

    // drv_temp/drv_sign are stable while drv_vld is high, so they are used unsynchronized
    assign mag       = {1'b0, drv_temp};
    assign temp_calc = drv_sign ? -mag : mag;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 26'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_inc;
        cont_d       = cont_q;
        temp_d       = temp_q;
        sample_vld_d = 1'b0;
        alarm_hi_d   = alarm_hi_q;
        alarm_lo_d   = alarm_lo_q;
        timeout_d    = timeout_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (start && !stop) begin
                    cont_d  = cont;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pulse_q) begin
                    // a result in flight wins over stop; clearing cont sends CAPTURE to IDLE
                    state_d      = S_CAPTURE;
                    temp_d       = temp_calc;
                    sample_vld_d = 1'b1;
                    alarm_hi_d   = temp_calc > HI_THRESH;
                    alarm_lo_d   = temp_calc < LO_THRESH;
                    timeout_d    = 1'b0;
                    if (stop) cont_d = 1'b0;
                end else if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = cont_q ? S_WAIT : S_IDLE;
                end
            end
            S_CAPTURE: begin
                cnt_d   = '0;
                state_d = (cont_q && !stop) ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == PERIOD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        drv_enable_d = (state_d == S_RUN);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cont_q       <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            pulse_q      <= 1'b0;
            drv_enable_q <= 1'b0;
            temp_q       <= '0;
            sample_vld_q <= 1'b0;
            alarm_hi_q   <= 1'b0;
            alarm_lo_q   <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cont_q       <= cont_d;
            sync1_q      <= drv_vld;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            pulse_q      <= sync2_q & ~sync3_q;
            drv_enable_q <= drv_enable_d;
            temp_q       <= temp_d;
            sample_vld_q <= sample_vld_d;
            alarm_hi_q   <= alarm_hi_d;
            alarm_lo_q   <= alarm_lo_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign drv_enable  = drv_enable_q;
    assign temp_out    = temp_q;
    assign sample_vld  = sample_vld_q;
    assign alarm_hi    = alarm_hi_q;
    assign alarm_lo    = alarm_lo_q;
    assign timeout_err = timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Randomized bench for temp_sample_ctrl: each sample's value, alarms and timing
// are predicted from integer arithmetic on the driver inputs.
module tb_temp_sample_ctrl;

    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 1000;
    localparam int HI      = 500000;
    localparam int LO      = -100000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic        stop;
    logic        drv_enable;
    logic [20:0] drv_temp;
    logic        drv_sign;
    logic        drv_vld;
    logic [21:0] temp_out;
    logic        sample_vld;
    logic        alarm_hi;
    logic        alarm_lo;
    logic        timeout_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;

    temp_sample_ctrl #(
        .PERIOD_CYC (PERIOD),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .stop       (stop),
        .drv_enable (drv_enable),
        .drv_temp   (drv_temp),
        .drv_sign   (drv_sign),
        .drv_vld    (drv_vld),
        .temp_out   (temp_out),
        .sample_vld (sample_vld),
        .alarm_hi   (alarm_hi),
        .alarm_lo   (alarm_lo),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) if (sample_vld) pulse_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic c);
        start = 1'b1;
        cont  = c;
        tick(1);
        start = 1'b0;
        cont  = 1'b0;
        check("en_after_start", int'(drv_enable), 1);
    endtask

    // One driver result; expect_rise means the next enable must follow after PERIOD.
    task automatic do_sample(input logic [20:0] t, input logic s, input bit expect_rise,
                             input int stop_at);
        int exp_val;
        int n0;
        int gap;
        exp_val = s ? -int'(t) : int'(t);
        n0 = pulse_cnt;
        drv_temp = t;
        drv_sign = s;
        drv_vld  = 1'b1;
        tick(3);
        check("early_vld", int'(sample_vld), 0);
        tick(1);
        check("sample_vld", int'(sample_vld), 1);
        check("temp_out", int'($signed(temp_out)), exp_val);
        check("alarm_hi", int'(alarm_hi), int'(exp_val > HI));
        check("alarm_lo", int'(alarm_lo), int'(exp_val < LO));
        check("timeout_clr", int'(timeout_err), 0);
        check("en_capture", int'(drv_enable), 0);
        $display("sample t=%0d s=%0d -> temp_out=%0d hi=%0d lo=%0d", t, s,
                 $signed(temp_out), alarm_hi, alarm_lo);
        gap = -1;
        for (int i = 1; i <= 400; i++) begin
            tick(1);
            if (i == 1) check("busy_after_cap", int'(busy), int'(expect_rise || stop_at > 0));
            if (i == 21) drv_vld = 1'b0;
            if (stop_at > 0 && i == stop_at) stop = 1'b1;
            if (stop_at > 0 && i == stop_at + 1) begin
                stop = 1'b0;
                check("stop_busy", int'(busy), 0);
                check("stop_en", int'(drv_enable), 0);
                check("stop_temp_held", int'($signed(temp_out)), exp_val);
                check("stop_hi_held", int'(alarm_hi), int'(exp_val > HI));
                check("stop_lo_held", int'(alarm_lo), int'(exp_val < LO));
            end
            if (gap < 0 && drv_enable) gap = i - 1;
            if (i >= 21 && (gap >= 0 || (!expect_rise && i >= 250))) break;
        end
        if (expect_rise) check("period_gap", gap, PERIOD);
        else check("no_reenable", gap, -1);
        check("one_pulse", pulse_cnt - n0, 1);
    endtask

    task automatic rand_val(output logic [20:0] t, output logic s);
        case ($urandom_range(0, 5))
            0: begin t = 21'(HI);      s = 1'b0; end
            1: begin t = 21'(HI + 1);  s = 1'b0; end
            2: begin t = 21'(-LO);     s = 1'b1; end
            3: begin t = 21'(-LO + 1); s = 1'b1; end
            default: begin t = 21'($urandom_range(0, 1999999)); s = 1'($urandom_range(0, 1)); end
        endcase
    endtask

    initial begin
        logic [20:0] t;
        logic        s;
        int          en_cnt;
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; stop = 1'b0;
        drv_temp = '0; drv_sign = 1'b0; drv_vld = 1'b0;
        tick(3);
        check("rst_en", int'(drv_enable), 0);
        check("rst_temp", int'(temp_out), 0);
        check("rst_vld", int'(sample_vld), 0);
        check("rst_flags", int'({alarm_hi, alarm_lo, timeout_err, busy}), 0);
        rst_n = 1'b1;
        tick(2);

        // single shot, fixed value
        start_req(1'b0);
        tick(300);
        do_sample(21'd253750, 1'b0, 1'b0, 0);
        check("single_idle", int'(busy), 0);

        // negative alarm
        start_req(1'b0);
        tick(50);
        do_sample(21'd125000, 1'b1, 1'b0, 0);

        // start while running is ignored: cont stays 0
        start_req(1'b0);
        tick(5);
        start = 1'b1; cont = 1'b1;
        tick(1);
        start = 1'b0; cont = 1'b0;
        do_sample(21'd1000, 1'b0, 1'b0, 0);

        // randomized single shots
        for (int k = 0; k < 6; k++) begin
            rand_val(t, s);
            start_req(1'b0);
            tick($urandom_range(1, 300));
            do_sample(t, s, 1'b0, 0);
        end

        // continuous mode, three samples
        start_req(1'b1);
        for (int k = 0; k < 3; k++) begin
            rand_val(t, s);
            tick($urandom_range(5, 100));
            do_sample(t, s, 1'b1, 0);
        end
        // fourth sample with stop during WAIT
        rand_val(t, s);
        tick(10);
        do_sample(t, s, 1'b0, 10);

        // timeout
        start_req(1'b0);
        en_cnt = 1;
        for (int i = 0; i < 1100; i++) begin
            tick(1);
            if (drv_enable) en_cnt++;
            else break;
        end
        check("timeout_cycles", en_cnt, TIMEOUT);
        check("timeout_err", int'(timeout_err), 1);
        check("timeout_idle", int'(busy), 0);
        start_req(1'b0);
        tick(20);
        do_sample(21'd200000, 1'b0, 1'b0, 0);

        // start and stop together resolve as stop
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", int'(busy), 0);
        check("start_stop_en", int'(drv_enable), 0);

        // reset mid-RUN drops everything asynchronously
        start_req(1'b1);
        tick(20);
        rst_n = 1'b0;
        #1;
        check("arst_en", int'(drv_enable), 0);
        check("arst_temp", int'(temp_out), 0);
        check("arst_flags", int'({sample_vld, alarm_hi, alarm_lo, timeout_err, busy}), 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("post_rst_idle", int'({busy, drv_enable}), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/temp_sample_ctrl.md
TEMP_SAMPLE_CTRL -- requirements
Module: temp_sample_ctrl

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
  - PERIOD_CYC, 50_000_000, gap in clk cycles from end of one sample to the next enable in continuous mode.
  - TIMEOUT_CYC, 50_000_000, maximum clk cycles with drv_enable high and no valid result.
  - HI_THRESH, 22'sd500000, signed high alarm limit (+50.0000 C, units of 0.0001 C).
  - LO_THRESH, -22'sd100000, signed low alarm limit (-10.0000 C).
REQ-002 SHALL provide ports (name, direction, width, meaning):
  - clk, in, 1, 50 MHz system clock.
  - rst_n, in, 1, asynchronous active-low reset.
  - start, in, 1, single-cycle request for one sample (single mode) or start of continuous mode.
  - cont, in, 1, 1 = continuous sampling, 0 = single shot; sampled when start is accepted.
  - stop, in, 1, single-cycle abort to IDLE.
  - drv_enable, out, 1, enable to the DS18B20 driver.
  - drv_temp, in, 21, driver magnitude result (x0.0001 C).
  - drv_sign, in, 1, driver sign bit (1 = negative).
  - drv_vld, in, 1, driver result-valid level, high for about 25 clk cycles, generated in the driver's divided-clock domain.
  - temp_out, out, 22, signed two's-complement temperature (x0.0001 C).
  - sample_vld, out, 1, one-cycle pulse when temp_out updates.
  - alarm_hi, out, 1, last sample > HI_THRESH.
  - alarm_lo, out, 1, last sample < LO_THRESH.
  - timeout_err, out, 1, sticky error flag.
  - busy, out, 1, high in any state other than IDLE.
REQ-003 SHALL use reset rst_n, asynchronous, active-low, and clock clk; all flops are on clk.

Function
REQ-004 SHALL pass drv_vld through a 2-flop synchronizer and then a rising-edge detector; only the detected edge (vld_pulse) counts as a result.
REQ-005 SHALL sample drv_temp and drv_sign on the vld_pulse cycle; no additional synchronization of these is required because they are stable while drv_vld is high.
REQ-006 SHALL implement the FSM states IDLE, RUN, CAPTURE, WAIT.
REQ-007 IDLE: drv_enable=0; on start, latch cont, clear the cycle counter, and go to RUN.
  - drv_enable is high on the cycle after start.
REQ-008 RUN: drv_enable=1 and the cycle counter increments.
  - On vld_pulse, go to CAPTURE.
  - Else, when the counter reaches TIMEOUT_CYC-1, set timeout_err=1 and go to WAIT (if cont) or IDLE (if not cont).
REQ-009 CAPTURE (one cycle): drv_enable=0.
  - temp_out = drv_sign ? -{1'b0,drv_temp} : {1'b0,drv_temp}, computed in 22-bit two's complement.
  - sample_vld=1 for exactly this cycle.
  - alarm_hi and alarm_lo update using signed compares.
  - timeout_err clears.
  - Next state is WAIT if cont, else IDLE.
REQ-010 WAIT: drv_enable=0 and the counter counts PERIOD_CYC cycles, then goes to RUN with the counter cleared.
  - The first drv_enable-high cycle is exactly PERIOD_CYC cycles after entering WAIT.
REQ-011 Total latency from vld_pulse to sample_vld SHALL be one cycle, i.e. 4 clk cycles after the raw drv_vld rise.
REQ-012 stop SHALL force IDLE on the next cycle from any state, with drv_enable=0 on that cycle.
  - Stop does not alter temp_out, the alarm flags or timeout_err.
  - A capture in progress on the stop cycle completes first (CAPTURE has priority, then IDLE).
REQ-013 start when not in IDLE SHALL be ignored; start and stop in the same cycle resolve as stop.
REQ-014 A vld_pulse arriving outside RUN SHALL be ignored.
REQ-015 alarm_hi and alarm_lo SHALL be mutually exclusive whenever HI_THRESH >= LO_THRESH.
  - A value equal to either threshold raises neither alarm.
REQ-016 The counter SHALL be 26 bits wide and saturate rather than wrap.

Reset
REQ-017 During reset SHALL hold state=IDLE, drv_enable=0, temp_out=0, sample_vld=0, alarm_hi=0, alarm_lo=0, timeout_err=0, busy=0, synchronizer flops=0, counter=0.
REQ-018 Reset asserted mid-RUN SHALL drop drv_enable asynchronously; after release the block stays in IDLE until start.

Verification (PERIOD_CYC=200, TIMEOUT_CYC=1000)
REQ-019 Single shot: start with cont=0, drv_vld rises 300 cycles later with temp=253750 and sign=0.
  - Required: temp_out=+253750 and one sample_vld pulse 4 cycles after the drv_vld rise.
  - Required: alarm_hi=0, alarm_lo=0, then IDLE with busy=0.
REQ-020 Negative alarm: temp=125000, sign=1.
  - Required: temp_out=-125000 (22'h3E17B8), alarm_lo=1, alarm_hi=0.
REQ-021 Continuous: start with cont=1 and a valid sample each RUN.
  - Required: drv_enable falls at CAPTURE and rises again exactly 200 cycles later.
  - Required: 3 samples yield 3 sample_vld pulses.
REQ-022 Timeout: start with cont=0 and no drv_vld.
  - Required: timeout_err=1 and drv_enable=0 after 1000 enabled cycles; a later good sample clears timeout_err.
REQ-023 Abort/reset: stop during WAIT gives IDLE next cycle with outputs held; rst_n low during RUN clears all outputs.
  - Required: drv_vld held high for 25 cycles produces only one sample_vld.
